// File: rtl/gate_driver.sv
// -----------------------------------------------------------------------------
// gate_driver
//
// Half-bridge gate command generator with dead-time insertion, a per-half-period
// watchdog and an optional overcurrent shutdown path.
//
// A burst runs while en_i is high. The phase reference in_i selects which gate
// is commanded: in_i=1 drives the high side (out_a_o) and in_i=0 drives the low
// side (out_b_o). Every gate turn-on is preceded by a dead interval of DT cycles
// with both gates low. A stop request never truncates the half-period in
// progress, so switch-off always happens at an in_i edge. The exception is a
// watchdog expiry, which switches off at once and latches fault_o.
//
// Build option:
//   GATE_DRIVER_OCD_EN  when defined, ocd_i passes through a 2-flop synchronizer.
//                       A synchronized high while busy latches fault_o and
//                       requests a stop. When undefined, ocd_i is ignored.
//
// Parameters:
//   CLK_MHZ       clock frequency in MHz
//   DEAD_TIME_NS  dead time before every turn-on; DT = CLK_MHZ*DEAD_TIME_NS/1000 (min 1)
//   MAX_HALF_US   longest allowed half-period;   WD = CLK_MHZ*MAX_HALF_US (min 1)
//
// Ports:
//   clk      in   single clock, all logic on posedge
//   rst      in   asynchronous active-high reset
//   en_i     in   interrupter enable, burst runs while high
//   in_i     in   phase reference from the gen/fb selector
//   ocd_i    in   overcurrent comparator, asynchronous to clk
//   out_a_o  out  high-side gate command, active-high, registered
//   out_b_o  out  low-side gate command, active-high, registered
//   busy_o   out  high in every state except IDLE, registered
//   fault_o  out  latched overcurrent / watchdog flag
// -----------------------------------------------------------------------------
module gate_driver #(
   parameter int CLK_MHZ      = 100,
   parameter int DEAD_TIME_NS = 50,
   parameter int MAX_HALF_US  = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic in_i,
   input  logic ocd_i,
   output logic out_a_o,
   output logic out_b_o,
   output logic busy_o,
   output logic fault_o
);

   // ---------------------------------------------------------------------------
   // Derived timing constants
   // ---------------------------------------------------------------------------
   localparam int DT_RAW = (CLK_MHZ * DEAD_TIME_NS) / 1000;
   localparam int DT     = (DT_RAW < 1) ? 1 : DT_RAW;
   localparam int WD_RAW = CLK_MHZ * MAX_HALF_US;
   localparam int WD     = (WD_RAW < 1) ? 1 : WD_RAW;

   // Each counter counts down from (N-1) to 0, so it needs clog2(N) bits.
   localparam int DT_W = (DT > 1) ? $clog2(DT) : 1;
   localparam int WD_W = (WD > 1) ? $clog2(WD) : 1;

   localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DT - 1);
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WD - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DEAD_A  = 3'd1,
      DRIVE_A = 3'd2,
      DEAD_B  = 3'd3,
      DRIVE_B = 3'd4,
      STOP    = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [DT_W-1:0]   dead_q,  dead_d;   // shared by DEAD_x and STOP
   logic [WD_W-1:0]   wd_q,    wd_d;
   logic              stop_q,  stop_d;
   logic              fault_q, fault_d;
   logic              out_a_q, out_b_q, busy_q;

   logic              ocd_evt;           // synchronized overcurrent level
   logic              busy_now;
   logic              stop_set;
   logic              stop_any;

   // ---------------------------------------------------------------------------
   // Overcurrent input conditioning
   // ---------------------------------------------------------------------------
`ifdef GATE_DRIVER_OCD_EN
   logic ocd_s1_q, ocd_s2_q;

   // ocd_i has no timing relationship to clk; two flops bring it into the
   // clock domain before any decision depends on it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ocd_s1_q <= 1'b0;
         ocd_s2_q <= 1'b0;
      end else begin
         ocd_s1_q <= ocd_i;
         ocd_s2_q <= ocd_s1_q;
      end
   end

   assign ocd_evt = ocd_s2_q;
`else
   logic unused_ocd;
   assign unused_ocd = ocd_i;
   assign ocd_evt    = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Stop request sources
   // ---------------------------------------------------------------------------
   assign busy_now = (state_q != IDLE);
   assign stop_set = busy_now & (~en_i | ocd_evt);
   // A request raised in the same cycle as an in_i edge still takes effect.
   assign stop_any = stop_q | stop_set;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so that no path
      // leaves it unassigned and no latch is inferred.
      state_d = state_q;
      dead_d  = dead_q;
      wd_d    = wd_q;
      stop_d  = stop_q | stop_set;
      fault_d = fault_q;

      if (busy_now && ocd_evt) begin
         fault_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (!en_i) begin
               // The only place where a latched fault can be acknowledged.
               fault_d = 1'b0;
            end else if (!fault_q) begin
               state_d = in_i ? DEAD_A : DEAD_B;
               dead_d  = DT_LOAD;
            end
         end

         DEAD_A: begin
            if (!in_i) begin
               // The phase reversed before the gate came on: the dead
               // interval restarts on the other side.
               state_d = DEAD_B;
               dead_d  = DT_LOAD;
            end else if (dead_q == '0) begin
               state_d = DRIVE_A;
               wd_d    = WD_LOAD;
            end else begin
               dead_d  = dead_q - DT_W'(1);
            end
         end

         DEAD_B: begin
            if (in_i) begin
               state_d = DEAD_A;
               dead_d  = DT_LOAD;
            end else if (dead_q == '0) begin
               state_d = DRIVE_B;
               wd_d    = WD_LOAD;
            end else begin
               dead_d  = dead_q - DT_W'(1);
            end
         end

         DRIVE_A: begin
            // A watchdog expiry overrides a coincident phase edge.
            if (wd_q == '0) begin
               state_d = STOP;
               dead_d  = DT_LOAD;
               fault_d = 1'b1;
            end else if (!in_i) begin
               state_d = stop_any ? STOP : DEAD_B;
               dead_d  = DT_LOAD;
            end else begin
               wd_d    = wd_q - WD_W'(1);
            end
         end

         DRIVE_B: begin
            if (wd_q == '0) begin
               state_d = STOP;
               dead_d  = DT_LOAD;
               fault_d = 1'b1;
            end else if (in_i) begin
               state_d = stop_any ? STOP : DEAD_A;
               dead_d  = DT_LOAD;
            end else begin
               wd_d    = wd_q - WD_W'(1);
            end
         end

         STOP: begin
            if (dead_q == '0) begin
               state_d = IDLE;
               stop_d  = 1'b0;
            end else begin
               dead_d  = dead_q - DT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   // The outputs are decoded from the next state and then registered. The
   // result matches the current state exactly and has no decode glitches at
   // the gate driver pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         dead_q  <= '0;
         wd_q    <= '0;
         stop_q  <= 1'b0;
         fault_q <= 1'b0;
         out_a_q <= 1'b0;
         out_b_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register here sample the
         // pre-edge values, independent of statement order.
         state_q <= state_d;
         dead_q  <= dead_d;
         wd_q    <= wd_d;
         stop_q  <= stop_d;
         fault_q <= fault_d;
         out_a_q <= (state_d == DRIVE_A);
         out_b_q <= (state_d == DRIVE_B);
         busy_q  <= (state_d != IDLE);
      end
   end

   assign out_a_o = out_a_q;
   assign out_b_o = out_b_q;
   assign busy_o  = busy_q;
   assign fault_o = fault_q;

endmodule

// File: tb/tb_gate_driver.sv
// -----------------------------------------------------------------------------
// tb_gate_driver
//
// Scoreboard bench for gate_driver. The stimulus process drives the inputs and
// advances a behavioural model. After each clock edge it queues the expected
// {out_a, out_b, busy, fault}. A monitor process pops one entry on every
// falling edge and compares it against the DUT outputs.
//
// The model describes a burst as "which side is targeted" plus remaining-cycle
// counts for the dead gap, the on-time and the cool-down.
// -----------------------------------------------------------------------------
module tb_gate_driver;

   localparam int CLK_MHZ      = 100;
   localparam int DEAD_TIME_NS = 50;
   localparam int MAX_HALF_US  = 10;
   localparam int DT = ((CLK_MHZ * DEAD_TIME_NS) / 1000 < 1) ? 1 : (CLK_MHZ * DEAD_TIME_NS) / 1000;
   localparam int WD = CLK_MHZ * MAX_HALF_US;

   logic clk = 1'b0;
   logic rst;
   logic en, in, ocd;
   logic out_a, out_b, busy, fault;

   int vectors     = 0;
   int miscompares = 0;

   gate_driver #(
      .CLK_MHZ      (CLK_MHZ),
      .DEAD_TIME_NS (DEAD_TIME_NS),
      .MAX_HALF_US  (MAX_HALF_US)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en_i    (en),
      .in_i    (in),
      .ocd_i   (ocd),
      .out_a_o (out_a),
      .out_b_o (out_b),
      .busy_o  (busy),
      .fault_o (fault)
   );

   always #5 clk = ~clk;

   // Queue entries are packed as {out_a, out_b, busy, fault}.
   logic [3:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // --------------------------------------------------------------------------
   // Behavioural reference model
   // --------------------------------------------------------------------------
   bit m_active;   // a burst (including its cool-down) is in progress
   bit m_side;     // 0: high side targeted, 1: low side targeted
   bit m_on;       // targeted gate currently conducting
   bit m_stop;     // stop requested, honour at the next phase edge
   bit m_fault;
   int m_dead;     // dead cycles still to elapse before turn-on
   int m_wd;       // on-cycles left before the watchdog trips
   int m_cool;     // cool-down cycles left (0 = not cooling)
   bit m_s1, m_s2; // overcurrent delay line

   function automatic void model_reset();
      m_active = 0; m_side = 0; m_on = 0; m_stop = 0; m_fault = 0;
      m_dead = 0; m_wd = 0; m_cool = 0; m_s1 = 0; m_s2 = 0;
   endfunction

   function automatic void model_step(input bit e, input bit i, input bit o);
      bit ocd_hit;
      bit req;
      bit want_in;
`ifdef GATE_DRIVER_OCD_EN
      ocd_hit = m_s2;
      m_s2    = m_s1;
      m_s1    = o;
`else
      ocd_hit = 1'b0;
      if (o) ocd_hit = 1'b0;
`endif
      req = m_active && (!e || ocd_hit);
      if (m_active && ocd_hit) m_fault = 1;
      want_in = (m_side == 0);

      if (!m_active) begin
         if (!e) m_fault = 0;
         else if (!m_fault) begin
            m_active = 1; m_on = 0; m_cool = 0;
            m_side = !i; m_dead = DT;
         end
      end else if (m_cool > 0) begin
         m_cool--;
         if (m_cool == 0) begin
            m_active = 0;
            m_stop   = 0;
         end
      end else if (!m_on) begin
         if (i != want_in) begin
            m_side = !m_side;
            m_dead = DT;
         end else begin
            m_dead--;
            if (m_dead == 0) begin
               m_on = 1;
               m_wd = WD;
            end
         end
      end else begin
         m_wd--;
         if (m_wd == 0) begin
            m_on = 0; m_cool = DT; m_fault = 1;
         end else if (i != want_in) begin
            m_on = 0;
            if (m_stop || req) m_cool = DT;
            else begin
               m_side = !m_side;
               m_dead = DT;
            end
         end
      end
      if (m_active) m_stop = m_stop | req;
   endfunction

   function automatic logic [3:0] model_out();
      return {m_active && m_on && !m_side, m_active && m_on && m_side, m_active, m_fault};
   endfunction

   // --------------------------------------------------------------------------
   // Stimulus: drive on the falling edge, step the model on the rising edge
   // --------------------------------------------------------------------------
   task automatic tick(input bit e, input bit i, input bit o);
      @(negedge clk);
      rst = 1'b0; en = e; in = i; ocd = o;
      @(posedge clk);
      model_step(e, i, o);
      exp_q.push_back(model_out());
   endtask

   // --------------------------------------------------------------------------
   // Monitor
   // --------------------------------------------------------------------------
   always @(negedge clk) begin : monitor
      logic [3:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("outputs", {28'd0, out_a, out_b, busy, fault}, {28'd0, e});
         check("no_overlap", {31'd0, out_a & out_b}, 32'd0);
      end
   end

   // --------------------------------------------------------------------------
   // Test sequence
   // --------------------------------------------------------------------------
   initial begin
      bit cur_in;
      bit cur_en;
      int half;

      rst = 1'b1; en = 1'b0; in = 1'b0; ocd = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 check("reset_state", {28'd0, out_a, out_b, busy, fault}, 32'd0);
      repeat (4) tick(0, 0, 0);

      // 200 kHz square wave at 100 MHz: half-period of 250 cycles.
      for (int p = 0; p < 4; p++) repeat (250) tick(1, (p % 2) == 0, 0);

      // en drops while the high side conducts; switch-off waits for in to fall.
      repeat (100) tick(1, 1, 0);
      repeat (50)  tick(0, 1, 0);
      repeat (20)  tick(0, 0, 0);

      // in stuck high: the watchdog trips, fault holds until en=0 in IDLE.
      repeat (1200) tick(1, 1, 0);
      repeat (3)    tick(0, 0, 0);

      // Two phase flips inside the first dead interval.
      repeat (2)  tick(1, 1, 0);
      tick(1, 0, 0);
      tick(1, 1, 0);
      repeat (20) tick(1, 1, 0);

      // Asynchronous reset while the high side conducts.
      @(negedge clk);
      #2 rst = 1'b1;
      exp_q.delete();
      model_reset();
      #1 check("async_reset", {28'd0, out_a, out_b, busy, fault}, 32'd0);
      repeat (3) tick(0, 0, 0);

      // Overcurrent pulse while the low side conducts (effective only with the
      // overcurrent build option).
      repeat (30) tick(1, 0, 0);
      tick(1, 0, 1);
      repeat (10) tick(1, 0, 0);
      repeat (20) tick(1, 1, 0);
      repeat (3)  tick(0, 0, 0);

      // Randomized bursts: mostly short half-periods, occasional watchdog trips,
      // sporadic enable drops and overcurrent pulses.
      cur_in = 1'b1;
      cur_en = 1'b1;
      repeat (400) begin
         half = ($urandom_range(0, 59) == 0) ? $urandom_range(990, 1010) : $urandom_range(1, 30);
         repeat (half) begin
            if ($urandom_range(0, 49) == 0) cur_en = !cur_en;
            tick(cur_en, cur_in, $urandom_range(0, 99) == 0);
         end
         cur_in = !cur_in;
      end
      repeat (3) tick(0, 0, 0);

      @(negedge clk);
      @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
